reg_chain_unit: RTL
===================

Name: reg_chain_unit

Overview:
- Parametrised successor to the PE single-stage register unit.
- Provides a configurable-latency data delay line of WIDTH bits, from 0 (bypass) up to MAX_DEPTH stages.
- Carries a valid bit alongside the data, exposes in-flight occupancy, and supports per-instance tie-off of enable and clear.
- Sits in the PE datapath between the FU output and the routing mux; used to balance path latencies in mapped dataflow graphs.

Parameters:
- WIDTH, 32, data width in bits.
- MAX_DEPTH, 4, number of physical stages; must be >= 1.
- TIE_EN, 0, if 1 the en input is ignored and treated as constant 1.
- TIE_CLR, 0, if 1 the clr input is ignored and treated as constant 0.
- INIT_VALUE, 0, WIDTH-bit value loaded into every data stage on reset or clear.
- DW, $clog2(MAX_DEPTH+1), derived width for cfg_depth and occupancy.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  stage-advance enable (global stall when 0).
- clr  input  1  synchronous clear; has priority over en.
- cfg_depth  input  DW  configured latency in cycles; quasi-static configuration.
- in_data  input  WIDTH  data into stage 0.
- in_valid  input  1  marks in_data as a real token.
- out_data  output  WIDTH  delayed data.
- out_valid  output  1  delayed valid.
- occupancy  output  DW  number of valid tokens in the active stages.

Behaviour:
- Effective depth D = min(cfg_depth, MAX_DEPTH). Values above MAX_DEPTH saturate.
- Effective enable e = TIE_EN ? 1 : en. Effective clear c = TIE_CLR ? 0 : clr.
- Storage: data stages s[0..MAX_DEPTH-1] and valid stages v[0..MAX_DEPTH-1].
- Reset (rst=0, asynchronous, immediate):
  - all s[i]=INIT_VALUE, all v[i]=0;
  - with D>0: out_data=INIT_VALUE, out_valid=0, occupancy=0.
- Priority on each rising edge with rst=1:
  - c=1: all s[i]=INIT_VALUE, all v[i]=0, regardless of e.
  - else e=1: s[0]<=in_data, v[0]<=in_valid; s[i]<=s[i-1], v[i]<=v[i-1] for i=1..MAX_DEPTH-1.
  - else: hold all stages.
- Shifting occurs on all physical stages regardless of D, so changing D re-taps an already-filled chain.
- Output selection:
  - D=0: out_data=in_data, out_valid=in_valid, purely combinational; occupancy=0.
  - D>=1: out_data=s[D-1], out_valid=v[D-1].
- Latency:
  - with e held 1, a token presented at edge k appears on the outputs after edge k+D-1 and is valid during the cycle preceding edge k+D;
  - with e=0 the chain freezes and latency stretches by the number of stalled cycles;
  - in_data/in_valid are not captured in stall cycles; the producer must hold them.
- occupancy = popcount of v[0..D-1]. Combinational from registers, glitch-free relative to clk. Maximum value is D. No wrap-around is possible.
- Invalid tokens (v=0) still shift their data; out_data is unconstrained meaningwise when out_valid=0 but must equal the shifted stage value.
- Simultaneous clr and in_valid: the token is dropped; the stage-0 valid bit becomes 0.
- cfg_depth change mid-stream:
  - takes effect combinationally;
  - tokens in stages >= new D are neither output nor counted;
  - software issues clr after reconfiguration.
- Reset asserted mid-stream: all tokens are lost immediately; no output glitch to valid=1.

Test Plan:
- Reset then D=3, e=1, inputs 0xA,0xB,0xC valid on consecutive edges -> out_valid first 1 after third edge with out_data=0xA, then 0xB, 0xC; occupancy peaks at 3.
- D=0, in_data=0x1234 with in_valid=1 -> out_data=0x1234, out_valid=1 in the same cycle; occupancy=0.
- D=2, stream 0x5, then en=0 for 3 cycles, then en=1 -> 0x5 emerges 3 cycles later than unstalled; occupancy stays 1 throughout the stall.
- D=4 full of valid tokens, assert clr with en=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=INIT_VALUE. Repeat with TIE_CLR=1 -> clr has no effect.
- cfg_depth=7 with MAX_DEPTH=4 -> behaves as D=4 (4-cycle latency). Change D from 4 to 2 mid-stream -> out_data immediately taps s[1]; occupancy recounts over 2 stages.
- Assert rst low between edges with tokens in flight -> out_valid=0 and occupancy=0 immediately. TIE_EN=1 with en=0 -> chain still advances every cycle.

Source files
------------

// File: rtl/reg_chain_unit.sv
// reg_chain_unit: configurable-latency delay line for the PE datapath.
// Carries data and a valid bit through up to MAX_DEPTH register stages,
// taps the output at the configured depth (0 = combinational bypass) and
// reports how many valid tokens sit in the active stages.
module reg_chain_unit #(
    parameter int              WIDTH      = 32,
    parameter int              MAX_DEPTH  = 4,
    parameter int              TIE_EN     = 0,
    parameter int              TIE_CLR    = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int              DW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DW-1:0]    cfg_depth,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [DW-1:0]    occupancy
);

    // Tied-off instances ignore the corresponding input entirely.
    logic en_eff;
    logic clr_eff;
    assign en_eff  = (TIE_EN  != 0) ? 1'b1 : en;
    assign clr_eff = (TIE_CLR != 0) ? 1'b0 : clr;

    // Depth requests beyond the physical chain saturate at MAX_DEPTH.
    logic [DW-1:0] d_eff;
    assign d_eff = (cfg_depth > DW'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : cfg_depth;

    logic [WIDTH-1:0]     s_reg [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] v_reg;
    logic [WIDTH-1:0]     s_in  [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] v_in;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
            // Stage 0 takes the producer; every later stage takes its predecessor.
            if (gi == 0) begin : g_head
                assign s_in[gi] = in_data;
                assign v_in[gi] = in_valid;
            end else begin : g_body
                assign s_in[gi] = s_reg[gi-1];
                assign v_in[gi] = v_reg[gi-1];
            end

            // Stage register: clear beats advance; all stages shift regardless of depth.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s_reg[gi] <= INIT_VALUE;
                    v_reg[gi] <= 1'b0;
                end else if (clr_eff) begin
                    s_reg[gi] <= INIT_VALUE;
                    v_reg[gi] <= 1'b0;
                end else if (en_eff) begin
                    s_reg[gi] <= s_in[gi];
                    v_reg[gi] <= v_in[gi];
                end
            end
        end
    endgenerate

    // Output tap at stage D-1 (bypass when D=0) and popcount of the active valid bits.
    always_comb begin
        out_data  = in_data;
        out_valid = in_valid;
        occupancy = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (d_eff == DW'(i + 1)) begin
                out_data  = s_reg[i];
                out_valid = v_reg[i];
            end
            if (DW'(i) < d_eff) begin
                occupancy = occupancy + DW'(v_reg[i]);
            end
        end
    end

endmodule
